// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - round-robin multi-port memory controller with per-transaction timeout
module mem_ctrl_arb #(
    parameter int NPORTS  = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 I_clk,
    input  logic                 I_reset_n,
    input  logic [NPORTS-1:0]    I_exec,
    input  logic [NPORTS-1:0]    I_write,
    input  logic [NPORTS*AW-1:0] I_addr,
    input  logic [NPORTS*DW-1:0] I_data,
    output logic [NPORTS-1:0]    O_ready,
    output logic [NPORTS-1:0]    O_grant,
    output logic [NPORTS-1:0]    O_data_ready,
    output logic [NPORTS-1:0]    O_error,
    output logic [DW-1:0]        O_data,
    input  logic                 MEM_ready,
    output logic                 MEM_exec,
    output logic                 MEM_write,
    output logic [AW-1:0]        MEM_addr,
    output logic [DW-1:0]        MEM_data_out,
    input  logic [DW-1:0]        MEM_data_in,
    input  logic                 MEM_data_ready
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    // Counter is wide enough to hold TIMEOUT itself so it can saturate there.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NPORTS-1:0] ONE  = NPORTS'(1);
    localparam logic [TW-1:0]     TLIM = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr;
    logic [PW-1:0]   cur;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    logic            pick_vld;
    logic [TW-1:0]   cnt;
    logic [TW-1:0]   cnt_inc;
    logic            grant;
    logic            done;
    logic            expire;
    logic            abort;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = PW'((int'(rr) + i) % NPORTS);
            if (!pick_vld && I_exec[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    // Completion/abort decode and next-state; completion beats a same-cycle expiry.
    always_comb begin
        cnt_inc   = (cnt == TLIM) ? cnt : cnt + 1'b1;
        expire    = (TIMEOUT > 0) && (cnt_inc == TLIM);
        grant     = (state == IDLE) && MEM_ready && pick_vld;
        done      = ((state == WAIT_RD) && MEM_data_ready) ||
                    ((state == WAIT_WR) && MEM_ready);
        abort     = ((state == WAIT_RD) || (state == WAIT_WR)) && !done && expire;
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = MEM_write ? WAIT_WR : WAIT_RD;
            WAIT_RD,
            WAIT_WR: if (done || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Controller FSM with registered handshake pulses and latched command.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state        <= IDLE;
            rr           <= '0;
            cur          <= '0;
            cnt          <= '0;
            O_ready      <= '0;
            O_grant      <= '0;
            O_data_ready <= '0;
            O_error      <= '0;
            O_data       <= '0;
            MEM_exec     <= 1'b0;
            MEM_write    <= 1'b0;
            MEM_addr     <= '0;
            MEM_data_out <= '0;
        end else begin
            state        <= state_nxt;
            MEM_exec     <= 1'b0;
            O_grant      <= '0;
            O_data_ready <= '0;
            O_error      <= '0;
            O_ready      <= ((state_nxt == IDLE) && MEM_ready) ? ~I_exec : '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        MEM_addr     <= I_addr[pick*AW +: AW];
                        MEM_data_out <= I_data[pick*DW +: DW];
                        MEM_write    <= I_write[pick];
                        MEM_exec     <= 1'b1;
                        O_grant      <= ONE << pick;
                        cur          <= pick;
                        rr           <= (pick == PW'(NPORTS - 1)) ? '0 : pick + 1'b1;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT_RD, WAIT_WR: begin
                    if (done) begin
                        O_data_ready <= ONE << cur;
                        if (state == WAIT_RD) O_data <= MEM_data_in;
                    end else if (abort) begin
                        O_error <= ONE << cur;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// tb/tb_mem_ctrl_arb.sv - directed scoreboard bench for mem_ctrl_arb
module tb_mem_ctrl_arb;

    logic        I_clk = 1'b0;
    logic        rst_n;

    logic [1:0]  exec, wr, o_ready, o_grant, o_dr, o_err;
    logic [31:0] addr, wdata;
    logic [15:0] o_data, mem_addr, mem_dout, mem_din;
    logic        mem_ready, mem_exec, mem_write, mem_dr;

    logic [3:0]  exec4, wr4, o_ready4, o_grant4, o_dr4, o_err4;
    logic [63:0] addr4, wdata4;
    logic [15:0] o_data4, mem_addr4, mem_dout4, mem_din4;
    logic        mem_ready4, mem_exec4, mem_write4, mem_dr4;

    typedef struct {
        logic [1:0]  port;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    int         gq[$];
    int         checks = 0;
    int         errors = 0;

    always #5 I_clk = ~I_clk;

    mem_ctrl_arb #(.NPORTS(2), .AW(16), .DW(16), .TIMEOUT(8)) dut (
        .I_clk(I_clk), .I_reset_n(rst_n),
        .I_exec(exec), .I_write(wr), .I_addr(addr), .I_data(wdata),
        .O_ready(o_ready), .O_grant(o_grant), .O_data_ready(o_dr),
        .O_error(o_err), .O_data(o_data),
        .MEM_ready(mem_ready), .MEM_exec(mem_exec), .MEM_write(mem_write),
        .MEM_addr(mem_addr), .MEM_data_out(mem_dout),
        .MEM_data_in(mem_din), .MEM_data_ready(mem_dr)
    );

    mem_ctrl_arb #(.NPORTS(4), .AW(16), .DW(16), .TIMEOUT(8)) dut4 (
        .I_clk(I_clk), .I_reset_n(rst_n),
        .I_exec(exec4), .I_write(wr4), .I_addr(addr4), .I_data(wdata4),
        .O_ready(o_ready4), .O_grant(o_grant4), .O_data_ready(o_dr4),
        .O_error(o_err4), .O_data(o_data4),
        .MEM_ready(mem_ready4), .MEM_exec(mem_exec4), .MEM_write(mem_write4),
        .MEM_addr(mem_addr4), .MEM_data_out(mem_dout4),
        .MEM_data_in(mem_din4), .MEM_data_ready(mem_dr4)
    );

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input logic [1:0] exp, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_grant != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk(tag, 32'(o_grant), 32'(exp));
        chk({tag, "_mem_exec"}, 32'(mem_exec), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (o_dr != 2'b00 || o_err != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_data_ready"}, 32'(o_dr), e.err ? 32'd0 : 32'(e.port));
                chk({tag, "_error"}, 32'(o_err), e.err ? 32'(e.port) : 32'd0);
                chk({tag, "_o_data"}, 32'(o_data), 32'(e.data));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        exec      = 2'b11;
        wr        = 2'b00;
        addr      = {16'h1234, 16'h0010};
        wdata     = 32'h0;
        mem_ready = 1'b1;
        mem_dr    = 1'b0;
        mem_din   = 16'h0;
        exec4     = 4'h0;
        wr4       = 4'h0;
        addr4     = {16'h0333, 16'h0222, 16'h0111, 16'h0000};
        wdata4    = 64'h0;
        mem_ready4 = 1'b1;
        mem_dr4   = 1'b1;
        mem_din4  = 16'hA5A5;

        // Reset held with both ports requesting: every output stays low.
        repeat (3) tick();
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_dr", 32'(o_dr), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_mem_exec", 32'(mem_exec), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        rst_n = 1'b1;

        // First grant after reset goes to port 0.
        wait_grant(2'b01, 1, "first_grant_p0");
        chk("p0_addr", 32'(mem_addr), 32'h0010);
        exec = 2'b10;
        tick();
        chk("issue_exec_low", 32'(mem_exec), 32'd0);
        mem_dr  = 1'b1;
        mem_din = 16'h1111;
        sb.push_back('{2'b01, 16'h1111, 1'b0});
        wait_done(1, "p0_read_min_latency");
        mem_dr = 1'b0;

        // Port 1 read of 0x1234, memory answers 3 cycles after MEM_exec.
        wait_grant(2'b10, 1, "grant_p1");
        chk("p1_addr", 32'(mem_addr), 32'h1234);
        chk("p1_write", 32'(mem_write), 32'd0);
        exec = 2'b00;
        tick();
        tick();
        mem_dr  = 1'b1;
        mem_din = 16'hBEEF;
        sb.push_back('{2'b10, 16'hBEEF, 1'b0});
        wait_done(1, "p1_read_beef");
        mem_dr  = 1'b0;
        mem_din = 16'hDEAD;
        tick();
        chk("p1_dr_one_cycle", 32'(o_dr), 32'd0);
        chk("p1_o_data_hold", 32'(o_data), 32'hBEEF);
        chk("idle_ready", 32'(o_ready), 32'h3);

        // Port 0 write with MEM_ready low for 4 cycles.
        exec  = 2'b01;
        wr    = 2'b01;
        addr  = {16'h0BAD, 16'h00A0};
        wdata = {16'h0000, 16'h5555};
        wait_grant(2'b01, 1, "grant_p0_wr");
        chk("wr_mem_write", 32'(mem_write), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h00A0);
        chk("wr_mem_dout", 32'(mem_dout), 32'h5555);
        exec      = 2'b00;
        wr        = 2'b00;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_busy_no_done", 32'(o_dr), 32'd0);
            chk("wr_busy_ready", 32'(o_ready), 32'd0);
        end
        mem_ready = 1'b1;
        sb.push_back('{2'b01, 16'hBEEF, 1'b0});
        wait_done(1, "p0_write_done");

        // Port 1 read never answered: error on the 8th WAIT_RD cycle.
        exec = 2'b10;
        wait_grant(2'b10, 2, "grant_p1_timeout");
        exec = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_no_err_early", 32'(o_err), 32'd0);
            chk("to_no_dr", 32'(o_dr), 32'd0);
        end
        sb.push_back('{2'b10, 16'hBEEF, 1'b1});
        wait_done(1, "p1_timeout");

        // Next request is still served; completion on expiry cycle wins.
        exec = 2'b01;
        addr = {16'h4444, 16'h0C00};
        wait_grant(2'b01, 2, "grant_after_timeout");
        chk("after_to_addr", 32'(mem_addr), 32'h0C00);
        exec = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("race_no_err_early", 32'(o_err), 32'd0);
        end
        mem_dr  = 1'b1;
        mem_din = 16'h7777;
        sb.push_back('{2'b01, 16'h7777, 1'b0});
        wait_done(1, "done_on_expiry");
        mem_dr = 1'b0;

        // Reset asserted during WAIT_RD drops the transaction.
        exec = 2'b10;
        wait_grant(2'b10, 2, "grant_p1_rst");
        exec = 2'b00;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_exec", 32'(mem_exec), 32'd0);
        chk("async_rst_dr", 32'(o_dr), 32'd0);
        chk("async_rst_err", 32'(o_err), 32'd0);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("async_rst_o_data", 32'(o_data), 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        mem_dr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_dr", 32'(o_dr), 32'd0);
            chk("post_rst_no_err", 32'(o_err), 32'd0);
        end
        chk("post_rst_ready", 32'(o_ready), 32'h3);
        mem_dr = 1'b0;

        // Four ports all requesting: grants rotate 0,1,2,3 three times.
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 4; p++)
                gq.push_back(p);
        exec4 = 4'hF;
        for (int n = 0; n < 12; n++) begin
            bit seen4;
            int exp_p;
            seen4 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (o_grant4 != 4'h0) begin
                    seen4 = 1'b1;
                    break;
                end
            end
            chk("rr4_seen", 32'(seen4), 32'd1);
            exp_p = gq.pop_front();
            chk("rr4_order", 32'(o_grant4), 32'd1 << exp_p);
        end
        exec4 = 4'h0;
        repeat (4) tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
